// File: rtl/sha1_rob_pkg.sv
// Shared types and helpers for the SHA-1 result reorder buffer.
// Release FSM encoding and pointer sizing used by the top level.
package sha1_rob_pkg;

  typedef logic [1:0] rob_state_t;

  localparam rob_state_t StIdle = 2'd0;
  localparam rob_state_t StRead = 2'd1;
  localparam rob_state_t StHold = 2'd2;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sha1_result_rob_if.sv
// Dispatcher, engine-result and egress signals of the SHA-1 result reorder buffer.
// master = surrounding logic, slave = the reorder buffer.
interface sha1_result_rob_if #(
  parameter int unsigned DATA_WIDTH = 160,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned TAG_WIDTH  = $clog2(DEPTH)
);

  logic                  alloc_req;
  logic                  alloc_gnt;
  logic [TAG_WIDTH-1:0]  alloc_tag;
  logic                  result_en;
  logic [TAG_WIDTH-1:0]  result_tag;
  logic [DATA_WIDTH-1:0] result_data;
  logic                  result_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAG_WIDTH-1:0]  out_tag;
  logic [TAG_WIDTH:0]    occupancy;

  modport master (
    output alloc_req, result_en, result_tag, result_data, out_ready,
    input  alloc_gnt, alloc_tag, result_err, out_valid, out_data, out_tag, occupancy
  );

  modport slave (
    input  alloc_req, result_en, result_tag, result_data, out_ready,
    output alloc_gnt, alloc_tag, result_err, out_valid, out_data, out_tag, occupancy
  );

endinterface

// File: rtl/sha1_rob_ram.sv
// Simple dual-port digest storage: one write port, one registered read port.
// Contents are not reset; validity is tracked outside in the vld bitmap.
module sha1_rob_ram #(
  parameter int unsigned DATA_WIDTH = 160,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sha1_result_rob.sv
// Reorder buffer for SHA-1 digests: hands out sequence tags, accepts results in
// any order and releases them strictly in tag order over valid/ready.
module sha1_result_rob
  import sha1_rob_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 160,
  parameter int unsigned DEPTH      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  sha1_result_rob_if.slave  rob
);

  localparam int unsigned TAG_WIDTH = $clog2(DEPTH);
  localparam int unsigned PtrW      = ptr_width(DEPTH);

  logic [PtrW-1:0]       alloc_ptr_q, alloc_ptr_d;
  logic [PtrW-1:0]       head_ptr_q, head_ptr_d;
  logic [PtrW-1:0]       occ;
  logic [DEPTH-1:0]      vld_q, vld_d;
  rob_state_t            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [TAG_WIDTH-1:0]  out_tag_q, out_tag_d;
  logic                  err_q, err_d;

  logic                  gnt;
  logic [TAG_WIDTH-1:0]  head_idx;
  logic [TAG_WIDTH-1:0]  tag_dist;
  logic                  wr_legal;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign occ      = alloc_ptr_q - head_ptr_q;
  assign gnt      = rob.alloc_req && (occ != PtrW'(DEPTH));
  assign head_idx = head_ptr_q[TAG_WIDTH-1:0];

  // Outstanding test is modulo DEPTH relative to head; a pending slot is refused.
  assign tag_dist = rob.result_tag - head_idx;
  assign wr_legal = rob.result_en && ({1'b0, tag_dist} < occ) && !vld_q[rob.result_tag];

  assign alloc_ptr_d = gnt ? alloc_ptr_q + PtrW'(1) : alloc_ptr_q;
  assign err_d       = rob.result_en && !wr_legal;

  always_comb begin
    state_d     = state_q;
    head_ptr_d  = head_ptr_q;
    vld_d       = vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    rd_en       = 1'b0;

    if (wr_legal) begin
      vld_d[rob.result_tag] = 1'b1;
    end

    // IDLE samples the registered bitmap, so a same-cycle head write waits a cycle.
    unique case (state_q)
      StIdle: begin
        if (vld_q[head_idx]) begin
          rd_en   = 1'b1;
          state_d = StRead;
        end
      end
      StRead: begin
        out_data_d  = ram_rdata;
        out_tag_d   = head_idx;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (rob.out_ready) begin
          vld_d[head_idx] = 1'b0;
          head_ptr_d      = head_ptr_q + PtrW'(1);
          out_valid_d     = 1'b0;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      head_ptr_q  <= '0;
      vld_q       <= '0;
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      head_ptr_q  <= head_ptr_d;
      vld_q       <= vld_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      err_q       <= err_d;
    end
  end

  sha1_rob_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (wr_legal),
    .waddr_i(rob.result_tag),
    .wdata_i(rob.result_data),
    .re_i   (rd_en),
    .raddr_i(head_idx),
    .rdata_o(ram_rdata)
  );

  assign rob.alloc_gnt  = gnt;
  assign rob.alloc_tag  = alloc_ptr_q[TAG_WIDTH-1:0];
  assign rob.result_err = err_q;
  assign rob.out_valid  = out_valid_q;
  assign rob.out_data   = out_data_q;
  assign rob.out_tag    = out_tag_q;
  assign rob.occupancy  = occ;

endmodule

// File: tb/tb_sha1_result_rob.sv
// Scoreboard bench for sha1_result_rob at DEPTH=8: directed vectors push the
// expected in-order releases, a negedge monitor pops and compares each transfer.
module tb_sha1_result_rob;

  localparam int DW    = 160;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sha1_result_rob_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sha1_result_rob #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rob  (bus)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got tag %0d data %0h, expected nothing",
                 bus.out_tag, bus.out_data);
      end else begin
        e = sb_q.pop_front();
        chk("out_tag", DW'(bus.out_tag), DW'(e.tag));
        chk("out_data", bus.out_data, e.data);
      end
    end
  end

  task automatic do_alloc(input logic [TW-1:0] exp_tag);
    bus.alloc_req = 1'b1;
    @(negedge clk);
    chk("alloc_gnt", DW'(bus.alloc_gnt), DW'(1));
    chk("alloc_tag", DW'(bus.alloc_tag), DW'(exp_tag));
    @(posedge clk); #1;
    bus.alloc_req = 1'b0;
  endtask

  task automatic do_write(input logic [TW-1:0] tag, input logic [DW-1:0] data,
                          input logic legal);
    bus.result_en   = 1'b1;
    bus.result_tag  = tag;
    bus.result_data = data;
    @(posedge clk); #1;
    bus.result_en = 1'b0;
    chk("result_err", DW'(bus.result_err), DW'(!legal));
  endtask

  task automatic wait_valid(input string name);
    int cyc = 0;
    while (!bus.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, DW'(bus.out_valid), DW'(1));
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((sb_q.size() != 0 || bus.out_valid) && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, DW'(sb_q.size()), DW'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.alloc_req   = 1'b1;
    bus.result_en   = 1'b0;
    bus.result_tag  = '0;
    bus.result_data = '0;
    bus.out_ready   = 1'b0;

    // Reset values; grant follows request while empty.
    #12;
    chk("rst_alloc_gnt", DW'(bus.alloc_gnt), DW'(1));
    chk("rst_alloc_tag", DW'(bus.alloc_tag), DW'(0));
    chk("rst_result_err", DW'(bus.result_err), DW'(0));
    chk("rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("rst_out_data", bus.out_data, DW'(0));
    chk("rst_out_tag", DW'(bus.out_tag), DW'(0));
    chk("rst_occupancy", DW'(bus.occupancy), DW'(0));
    bus.alloc_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // In-order: tags 0..3, first write also checks the 3-cycle latency.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) do_alloc(TW'(i));
    chk("io_occupancy", DW'(bus.occupancy), DW'(4));
    sb_q.push_back('{tag: TW'(0), data: DW'(32'hA0)});
    do_write(TW'(0), DW'(32'hA0), 1'b1);
    @(negedge clk);
    chk("lat_n1", DW'(bus.out_valid), DW'(0));
    @(negedge clk);
    chk("lat_n2", DW'(bus.out_valid), DW'(0));
    @(negedge clk);
    chk("lat_n3", DW'(bus.out_valid), DW'(1));
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) begin
      sb_q.push_back('{tag: TW'(i), data: DW'(32'hA0 + i)});
      do_write(TW'(i), DW'(32'hA0 + i), 1'b1);
    end
    drain("io_drain");
    chk("io_occ_end", DW'(bus.occupancy), DW'(0));

    // Out-of-order: tags 4..7 written 7,5,6 then 4.
    for (int i = 4; i < 8; i++) do_alloc(TW'(i));
    for (int i = 4; i < 8; i++) sb_q.push_back('{tag: TW'(i), data: DW'(32'hB0 + i)});
    do_write(TW'(7), DW'(32'hB7), 1'b1);
    do_write(TW'(5), DW'(32'hB5), 1'b1);
    do_write(TW'(6), DW'(32'hB6), 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("ooo_no_valid", DW'(bus.out_valid), DW'(0));
    do_write(TW'(4), DW'(32'hB4), 1'b1);
    drain("ooo_drain");

    // Full: 8 tags out, 9th refused, release frees a grant one cycle later.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) do_alloc(TW'(i));
    chk("full_occupancy", DW'(bus.occupancy), DW'(8));
    bus.alloc_req = 1'b1;
    @(negedge clk);
    chk("full_gnt", DW'(bus.alloc_gnt), DW'(0));
    @(posedge clk); #1;
    bus.alloc_req = 1'b0;
    sb_q.push_back('{tag: TW'(0), data: DW'(32'hC0)});
    do_write(TW'(0), DW'(32'hC0), 1'b1);
    wait_valid("full_valid");
    bus.alloc_req = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("full_gnt_release_cycle", DW'(bus.alloc_gnt), DW'(0));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("wrap_gnt", DW'(bus.alloc_gnt), DW'(1));
    chk("wrap_tag", DW'(bus.alloc_tag), DW'(0));
    @(posedge clk); #1;
    bus.alloc_req = 1'b0;
    chk("wrap_occupancy", DW'(bus.occupancy), DW'(8));
    bus.out_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      sb_q.push_back('{tag: TW'(i), data: DW'(32'hC0 + i)});
      do_write(TW'(i), DW'(32'hC0 + i), 1'b1);
    end
    sb_q.push_back('{tag: TW'(0), data: DW'(32'hD0)});
    do_write(TW'(0), DW'(32'hD0), 1'b1);
    drain("full_drain");
    chk("full_occ_end", DW'(bus.occupancy), DW'(0));

    // Illegal writes and stall: tags 1,2 outstanding.
    bus.out_ready = 1'b0;
    do_alloc(TW'(1));
    do_alloc(TW'(2));
    chk("ill_occupancy", DW'(bus.occupancy), DW'(2));
    do_write(TW'(5), DW'(32'hE5), 1'b0);
    sb_q.push_back('{tag: TW'(1), data: DW'(32'hE1)});
    do_write(TW'(1), DW'(32'hE1), 1'b1);
    wait_valid("ill_valid");
    do_write(TW'(1), DW'(32'hEE), 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tag", DW'(bus.out_tag), DW'(1));
      chk("stall_data", bus.out_data, DW'(32'hE1));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("stall_one_xfer", DW'(bus.out_valid), DW'(0));
    chk("stall_occupancy", DW'(bus.occupancy), DW'(1));
    bus.out_ready = 1'b1;
    sb_q.push_back('{tag: TW'(2), data: DW'(32'hE2)});
    do_write(TW'(2), DW'(32'hE2), 1'b1);
    drain("ill_drain");

    // Reset mid-flight: tags 3..6 out, 3 and 4 written, tag 3 presented.
    bus.out_ready = 1'b0;
    for (int i = 3; i < 7; i++) do_alloc(TW'(i));
    do_write(TW'(3), DW'(32'hF3), 1'b1);
    do_write(TW'(4), DW'(32'hF4), 1'b1);
    wait_valid("mid_valid");
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", DW'(bus.out_valid), DW'(0));
    chk("mid_rst_occupancy", DW'(bus.occupancy), DW'(0));
    chk("mid_rst_out_tag", DW'(bus.out_tag), DW'(0));
    chk("mid_rst_out_data", bus.out_data, DW'(0));
    chk("mid_rst_alloc_tag", DW'(bus.alloc_tag), DW'(0));
    chk("mid_rst_result_err", DW'(bus.result_err), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_alloc(TW'(0));
    chk("post_rst_occupancy", DW'(bus.occupancy), DW'(1));
    bus.out_ready = 1'b1;
    sb_q.push_back('{tag: TW'(0), data: DW'(32'hF0)});
    do_write(TW'(0), DW'(32'hF0), 1'b1);
    drain("post_rst_drain");
    chk("post_rst_occ_end", DW'(bus.occupancy), DW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
